// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and access sequencer placing the CPU and loader onto one single-port RAM
//   Clock, Reset             : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU request (level, held until cpu_done)
//   cpu_gnt, cpu_done        : CPU owns the port / one-cycle completion pulse
//   ldr_req/we/addr/wdata    : loader request, same semantics as CPU
//   ldr_gnt, ldr_done        : loader grant / completion pulse
//   rd_data                  : last read result, shared by both requesters
//   ram_addr/wdata/we/re     : RAM port, strobes one cycle per access
//   ram_rdata                : RAM read data, RAM_LAT cycles after the ram_re cycle
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    logic [1:0] state;
    logic       owner;
    logic       last_gnt;
    logic       we_q;
    logic [2:0] cnt;
    logic       pick;
    // owner/last_gnt: 0 = CPU, 1 = loader; on a tie the one not served last wins
    assign pick = ldr_req && (!cpu_req || !last_gnt);
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            we_q      <= 1'b0;
            cnt       <= 3'd0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_data   <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (cpu_req || ldr_req) begin
                        owner     <= pick;
                        last_gnt  <= pick;
                        we_q      <= pick ? ldr_we : cpu_we;
                        ram_addr  <= pick ? ldr_addr : cpu_addr;
                        ram_wdata <= pick ? ldr_wdata : cpu_wdata;
                        state     <= S_ACCESS;
                    end
                S_ACCESS: begin
                    state <= we_q ? S_DONE : S_WAIT;
                    cnt   <= 3'(RAM_LAT);
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rd_data <= ram_rdata;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    always_comb begin
        cpu_gnt  = state != S_IDLE && !owner;
        ldr_gnt  = state != S_IDLE && owner;
        cpu_done = state == S_DONE && !owner;
        ldr_done = state == S_DONE && owner;
        ram_we   = state == S_ACCESS && we_q;
        ram_re   = state == S_ACCESS && !we_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with RAM models of latency 1 and 3
module tb_mem_port_arbiter;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, cpu_req3 = 1'b0;
    logic [8:0]  cpu_addr = '0, ldr_addr = '0;
    logic [31:0] cpu_wdata = '0, ldr_wdata = '0;
    logic        cpu_gnt, cpu_done, ldr_gnt, ldr_done, ram_we, ram_re;
    logic [31:0] rd_data, ram_wdata, ram_rdata;
    logic [8:0]  ram_addr;
    logic        cpu_gnt3, cpu_done3, ldr_gnt3, ldr_done3, ram_we3, ram_re3;
    logic [31:0] rd_data3, ram_wdata3, ram_rdata3;
    logic [8:0]  ram_addr3;
    logic [31:0] mem [0:511];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];
    int n_chk = 0;
    int n_fail = 0;
    always #5 Clock = ~Clock;
    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) u_dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done),
        .rd_data(rd_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );
    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_done(cpu_done3),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(9'd0), .ldr_wdata(32'd0),
        .ldr_gnt(ldr_gnt3), .ldr_done(ldr_done3),
        .rd_data(rd_data3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_we(ram_we3), .ram_re(ram_re3), .ram_rdata(ram_rdata3)
    );
    // RAM models: data is only meaningful exactly RAM_LAT cycles after a read strobe
    assign ram_rdata  = p1;
    assign ram_rdata3 = p3[2];
    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        p1    <= ram_re ? mem[ram_addr] : 32'hBAD0_BAD0;
        p3[0] <= ram_re3 ? mem[ram_addr3] : 32'hBAD3_BAD3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask
    task automatic apply_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask
    initial begin
        int k;
        int ng;
        int order [0:7];
        logic both;
        logic pc;
        logic pl;
        // reset state
        tick(2);
        chk("rst_ctl", {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_we, ram_re}, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_addr", {ram_addr, ram_wdata}, 0);
        Reset = 1'b0;
        // CPU write 0x012 <- DEADBEEF
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h012; cpu_wdata = 32'hDEAD_BEEF;
        tick(1);
        chk("wr_we", {ram_we, ram_re, cpu_gnt, ldr_gnt, cpu_done}, 5'b10100);
        chk("wr_addr", ram_addr, 9'h012);
        chk("wr_data", ram_wdata, 32'hDEAD_BEEF);
        tick(1);
        chk("wr_done", {ram_we, cpu_gnt, ldr_gnt, cpu_done}, 4'b0101);
        cpu_req = 1'b0;
        tick(1);
        chk("wr_end", {ram_we, cpu_gnt, cpu_done}, 0);
        chk("wr_mem", mem[9'h012], 32'hDEAD_BEEF);
        // CPU read 0x012, RAM_LAT = 1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 32'h0;
        tick(1);
        chk("rd_re", {ram_re, ram_we, cpu_gnt}, 3'b101);
        tick(1);
        chk("rd_wait", {ram_re, cpu_done}, 0);
        tick(1);
        chk("rd_done", cpu_done, 1);
        chk("rd_data", rd_data, 32'hDEAD_BEEF);
        cpu_req = 1'b0;
        tick(1);
        chk("rd_end", {cpu_done, cpu_gnt}, 0);
        // CPU read 0x012 on the RAM_LAT = 3 instance
        cpu_req3 = 1'b1;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (cpu_done3) begin
                k = i;
                break;
            end
        end
        cpu_req3 = 1'b0;
        chk("lat3_edges", k, 5);
        chk("lat3_data", rd_data3, 32'hDEAD_BEEF);
        tick(1);
        chk("lat3_end", cpu_done3, 0);
        // loader write 0x100 then CPU read of 0x100 two cycles later
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 9'h100; ldr_wdata = 32'h0000_0A5A;
        tick(1);
        chk("lw_acc", {ldr_gnt, cpu_gnt, ram_we}, 3'b101);
        tick(1);
        chk("lw_done", {ldr_done, cpu_gnt}, 2'b10);
        ldr_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h100;
        tick(1);
        chk("cr_idle", {cpu_gnt, ldr_gnt, ldr_done}, 0);
        tick(1);
        chk("cr_acc", {cpu_gnt, ram_re}, 2'b11);
        chk("cr_addr", ram_addr, 9'h100);
        tick(2);
        chk("cr_done", cpu_done, 1);
        chk("cr_data", rd_data, 32'h0000_0A5A);
        cpu_req = 1'b0;
        tick(1);
        // loader read, reset during WAIT
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h012;
        tick(2);
        chk("lr_wait", {ldr_gnt, ram_re, ldr_done}, 3'b100);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ctl", {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_we, ram_re}, 0);
        chk("mid_rst_rd", rd_data, 0);
        chk("mid_rst_addr", ram_addr, 0);
        ldr_req = 1'b0;
        both = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            both = both | ldr_done | ldr_gnt | ram_re | ram_we;
        end
        chk("rst_held_quiet", both, 0);
        Reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h100;
        tick(3);
        chk("post_rst_done", {cpu_done, ldr_done}, 2'b10);
        chk("post_rst_data", rd_data, 32'h0000_0A5A);
        cpu_req = 1'b0;
        tick(1);
        // both request continuously from reset: strict alternation
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h001; cpu_wdata = 32'h1111_1111;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 9'h002; ldr_wdata = 32'h2222_2222;
        for (int i = 0; i < 8; i++) order[i] = -1;
        ng = 0; both = 1'b0; pc = 1'b0; pl = 1'b0;
        for (int i = 0; i < 40 && ng < 8; i++) begin
            tick(1);
            both = both | (cpu_gnt & ldr_gnt);
            if (cpu_gnt && !pc && ng < 8) begin order[ng] = 0; ng++; end
            if (ldr_gnt && !pl && ng < 8) begin order[ng] = 1; ng++; end
            pc = cpu_gnt;
            pl = ldr_gnt;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
        chk("rr_exclusive", both, 0);
        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single-port system RAM. Requester 0 is the CPU control unit's memory path (MAR/MDR Read/Write); requester 1 is the program loader/debug port that writes the program image and inspects memory. The block serialises both onto one RAM port with round-robin fairness and a req/gnt/done handshake. It absorbs a configurable RAM read latency so the control unit can hold its memory state until `cpu_done`.

## Interface
- `ADDR_W`, 9, RAM word-address width
- `DATA_W`, 32, data width
- `RAM_LAT`, 1, RAM read latency in cycles, legal range 1..4

- `Clock`  in  1  system clock, all state on rising edge
- `Reset`  in  1  reset; asynchronous, active-high
- `cpu_req`  in  1  CPU access request; level, held until `cpu_done`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  write data
- `cpu_gnt`  out  1  CPU owns the RAM port (ACCESS..DONE)
- `cpu_done`  out  1  one-cycle completion pulse for CPU
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`  in  1/1/ADDR_W/DATA_W  loader request, same semantics
- `ldr_gnt`, `ldr_done`  out  1/1  loader grant/done, same semantics
- `rd_data`  out  DATA_W  read result, shared; valid with either done after a read
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_we`  out  1  RAM write strobe, exactly one cycle per write
- `ram_re`  out  1  RAM read strobe, exactly one cycle per read
- `ram_rdata`  in  DATA_W  RAM read data, valid RAM_LAT cycles after the `ram_re` cycle

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - One request: grant it.
  - Both requests: grant the requester not served last (`last_gnt` register); reset value = loader, so CPU wins the first tie.
  - On grant: latch owner, we, addr, wdata; update `last_gnt`; go to ACCESS.
- **ACCESS**
  - `ram_addr`/`ram_wdata` driven from latches.
  - `ram_we` = latched we; `ram_re` = ~latched we.
  - Next state: write → DONE; read → WAIT, with `cnt` = RAM_LAT.
- **WAIT**
  - Decrement `cnt` each edge.
  - On the edge where `cnt` == 1: capture `ram_rdata` into `rd_data`, go to DONE.
- **DONE**
  - Owner's done = 1 for exactly one cycle; go to IDLE.
- Grant and strobe decode:
  - Owner's gnt = 1 in ACCESS, WAIT and DONE; both gnts = 0 in IDLE.
  - `ram_we`/`ram_re` = 0 outside ACCESS.
  - `ram_addr`/`ram_wdata` hold the latched values at all times.
- Request inputs are ignored outside IDLE. Changes to the owner's we/addr/wdata after the grant edge have no effect.
- The requester drops req in its done cycle. A req still high in the following IDLE is a new transaction.
- `rd_data` holds its value until the next read capture; writes leave it unchanged.
- The non-owner's req may assert at any time. It waits and is served at the next IDLE.

## Timing
- Reset values, applied asynchronously and immediately:
  - state = IDLE
  - all gnt/done/`ram_we`/`ram_re` = 0
  - `rd_data` = 0, `ram_addr` = 0, `ram_wdata` = 0
  - `last_gnt` = loader
- Reset mid-transaction abandons the access with no further strobes. A write strobe cut short may or may not commit.
- Let edge E0 be the IDLE edge that samples req:
  - Write: gnt high from E0; `ram_we` high E0..E1; done high E1..E2; gnt low after E2.
  - Read: `ram_re` high E0..E1; capture at E(1+RAM_LAT); done high for the following cycle. Request-to-done latency = 2+RAM_LAT edges.
- There is always at least one IDLE cycle between consecutive transactions.
- Throughput:
  - Writes: one per 3 cycles.
  - Reads: one per 3+RAM_LAT cycles.
- Fairness: with both requesters requesting continuously, grants strictly alternate. Maximum wait = one full transaction of the other requester plus one IDLE cycle.

## Test plan
- Reset, then hold `Reset`=1 mid-stimulus → all outputs 0 immediately, `rd_data` = 0, no strobes while reset is held.
- CPU write, addr 0x012, data 0xDEADBEEF → `ram_we` high exactly one cycle with `ram_addr` = 0x012 and `ram_wdata` = 0xDEADBEEF; `cpu_done` one cycle, 2 edges after E0; `ldr_gnt` stays 0.
- CPU read of 0x012, RAM model returns 0xDEADBEEF:
  - RAM_LAT = 1: `rd_data` = 0xDEADBEEF with `cpu_done`, 3 edges after E0.
  - RAM_LAT = 3: `cpu_done` 5 edges after E0.
- `cpu_req` and `ldr_req` asserted together right after reset, both held for four transactions each → grant order CPU, LDR, CPU, LDR; never both gnt = 1.
- Loader writes 0x0000_0A5A to 0x100 while CPU reads 0x100 two cycles later → CPU waits until after `ldr_done` + 1 IDLE cycle; CPU `rd_data` = 0x0000_0A5A.
- Reset asserted during WAIT of a loader read → `ldr_gnt` = 0 and `rd_data` = 0 immediately, no `ldr_done`; after release, a new CPU read completes normally.
